// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [15:0] HALT_CODE_DEFAULT = 16'hFFFF;
  localparam logic [7:0]  RESET_PC_DEFAULT  = 8'h00;

endpackage

// File: rtl/fetch_ctrl.sv
// Sequential fetch controller: walks an external ROM from RESET_PC, presents each
// word on a valid/ready output slot, stops after HALT_CODE, supports branches.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [7:0]  RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [15:0] HALT_CODE = HALT_CODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        branch_en,
  input  logic [7:0]  branch_target,
  output logic [7:0]  pc,
  input  logic [15:0] code,
  output logic [15:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy,
  output logic        halted,
  output logic [15:0] fetch_cnt
);

  state_t      state, state_n;
  logic [7:0]  pc_n;
  logic [15:0] instr_n;
  logic [7:0]  instr_pc_n;
  logic        instr_valid_n;
  logic [15:0] fetch_cnt_n;
  logic        accept;
  logic        slot_free;

  assign accept    = instr_valid && instr_ready;
  assign slot_free = !instr_valid || instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      fetch_cnt   <= fetch_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    // Accepts are counted even when a branch discards the following slot contents.
    fetch_cnt_n   = (accept && (fetch_cnt != '1)) ? fetch_cnt + 16'd1 : fetch_cnt;

    unique case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_n       = FETCH;
          pc_n          = RESET_PC;
          fetch_cnt_n   = '0;
          instr_valid_n = 1'b0;
        end
      end

      FETCH: begin
        if (branch_en) begin
          pc_n          = branch_target;
          instr_valid_n = 1'b0;
        end else if (slot_free) begin
          instr_n       = code;
          instr_pc_n    = pc;
          instr_valid_n = 1'b1;
          if (code != HALT_CODE) begin
            pc_n = pc + 8'd1;
          end else begin
            state_n = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (branch_en) begin
          state_n       = FETCH;
          pc_n          = branch_target;
          instr_valid_n = 1'b0;
        end else if (accept) begin
          state_n       = HALTED;
          instr_valid_n = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign busy   = (state == FETCH) || (state == DRAIN);
  assign halted = (state == HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl against a small program ROM (words 0..9, halt at 10).
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic [7:0]  pc;
  logic [15:0] code;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        halted;
  logic [15:0] fetch_cnt;

  int unsigned vectors   = 0;
  int unsigned miscompares = 0;

  fetch_ctrl #(.RESET_PC(8'h00), .HALT_CODE(16'hFFFF)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .pc            (pc),
    .code          (code),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .busy          (busy),
    .halted        (halted),
    .fetch_cnt     (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    logic [3:0] n;
    n = a[3:0];
    if (a <= 8'd9)       return {n, n, n, n};
    else if (a == 8'd10) return 16'hFFFF;
    else                 return 16'h0000;
  endfunction

  always_comb code = rom_word(pc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; branch_en = 1'b0; branch_target = 8'h00; instr_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({pc, instr, instr_pc, instr_valid, fetch_cnt, busy, halted} !== {8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: pc=%h instr=%h instr_pc=%h valid=%b cnt=%h busy=%b halted=%b, need all zero",
               pc, instr, instr_pc, instr_valid, fetch_cnt, busy, halted);
    end
    branch_en = 1'b1; branch_target = 8'h05;
    tick();
    branch_en = 1'b0;
    vectors++;
    if ({pc, busy, instr_valid} !== {8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL branch_in_idle: pc=%h busy=%b valid=%b, need pc=00 busy=0 valid=0", pc, busy, instr_valid);
    end
  endtask

  task automatic test_run();
    logic [15:0] w;
    start = 1'b1; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, pc, instr_valid} !== {1'b1, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL run_start: busy=%b pc=%h valid=%b, need busy=1 pc=00 valid=0", busy, pc, instr_valid);
    end
    for (int k = 0; k <= 10; k++) begin
      tick();
      w = rom_word(8'(k));
      vectors++;
      if ({instr, instr_pc, instr_valid, busy} !== {w, 8'(k), 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL run_word%0d: instr=%h instr_pc=%h valid=%b busy=%b, need instr=%h instr_pc=%h valid=1 busy=1",
                 k, instr, instr_pc, instr_valid, busy, w, 8'(k));
      end
    end
    tick();
    vectors++;
    if ({halted, busy, instr_valid, fetch_cnt, pc} !== {1'b1, 1'b0, 1'b0, 16'd11, 8'd10}) begin
      miscompares++;
      $display("FAIL run_halt: halted=%b busy=%b valid=%b cnt=%0d pc=%h, need halted=1 busy=0 valid=0 cnt=11 pc=0a",
               halted, busy, instr_valid, fetch_cnt, pc);
    end
  endtask

  task automatic test_stall();
    logic [15:0] w;
    start = 1'b1; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({fetch_cnt, halted, busy, pc} !== {16'd0, 1'b0, 1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL restart: cnt=%0d halted=%b busy=%b pc=%h, need cnt=0 halted=0 busy=1 pc=00", fetch_cnt, halted, busy, pc);
    end
    repeat (4) tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({instr, instr_pc, pc, instr_valid, fetch_cnt} !== {16'h3333, 8'd3, 8'd4, 1'b1, 16'd3}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: instr=%h instr_pc=%h pc=%h valid=%b cnt=%0d, need 3333/03/04/1/3",
                 i, instr, instr_pc, pc, instr_valid, fetch_cnt);
      end
    end
    instr_ready = 1'b1;
    for (int k = 4; k <= 10; k++) begin
      tick();
      w = rom_word(8'(k));
      vectors++;
      if ({instr, instr_pc, instr_valid} !== {w, 8'(k), 1'b1}) begin
        miscompares++;
        $display("FAIL stall_resume%0d: instr=%h instr_pc=%h valid=%b, need %h/%h/1", k, instr, instr_pc, instr_valid, w, 8'(k));
      end
    end
    tick();
    vectors++;
    if ({halted, fetch_cnt} !== {1'b1, 16'd11}) begin
      miscompares++;
      $display("FAIL stall_halt: halted=%b cnt=%0d, need halted=1 cnt=11", halted, fetch_cnt);
    end
  endtask

  task automatic test_branch();
    start = 1'b1; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    instr_ready = 1'b0; branch_en = 1'b1; branch_target = 8'd8;
    tick();
    branch_en = 1'b0; instr_ready = 1'b1;
    vectors++;
    if ({instr_valid, pc, fetch_cnt, busy} !== {1'b0, 8'd8, 16'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL branch_drop: valid=%b pc=%h cnt=%0d busy=%b, need valid=0 pc=08 cnt=2 busy=1", instr_valid, pc, fetch_cnt, busy);
    end
    tick();
    vectors++;
    if ({instr, instr_pc, instr_valid, fetch_cnt} !== {16'h8888, 8'd8, 1'b1, 16'd2}) begin
      miscompares++;
      $display("FAIL branch_target_word: instr=%h instr_pc=%h valid=%b cnt=%0d, need 8888/08/1/2", instr, instr_pc, instr_valid, fetch_cnt);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({instr, instr_pc, instr_valid, fetch_cnt, busy} !== {16'hFFFF, 8'd10, 1'b1, 16'd4, 1'b1}) begin
      miscompares++;
      $display("FAIL start_in_fetch: instr=%h instr_pc=%h valid=%b cnt=%0d busy=%b, need ffff/0a/1/4/1",
               instr, instr_pc, instr_valid, fetch_cnt, busy);
    end
    branch_en = 1'b1; branch_target = 8'hFF;
    tick();
    branch_en = 1'b0;
    vectors++;
    if ({fetch_cnt, instr_valid, pc, busy, halted} !== {16'd5, 1'b0, 8'hFF, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL branch_in_drain: cnt=%0d valid=%b pc=%h busy=%b halted=%b, need cnt=5 valid=0 pc=ff busy=1 halted=0",
               fetch_cnt, instr_valid, pc, busy, halted);
    end
    tick();
    vectors++;
    if ({instr, instr_pc, instr_valid, pc, busy} !== {16'h0000, 8'hFF, 1'b1, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_ff: instr=%h instr_pc=%h valid=%b pc=%h busy=%b, need 0000/ff/1/00/1", instr, instr_pc, instr_valid, pc, busy);
    end
    tick();
    vectors++;
    if ({instr, instr_pc, instr_valid, busy} !== {16'h0000, 8'h00, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_00: instr=%h instr_pc=%h valid=%b busy=%b, need 0000/00/1/1", instr, instr_pc, instr_valid, busy);
    end
    tick();
    vectors++;
    if ({instr, instr_pc, fetch_cnt} !== {16'h1111, 8'h01, 16'd7}) begin
      miscompares++;
      $display("FAIL wrap_next: instr=%h instr_pc=%h cnt=%0d, need 1111/01/7", instr, instr_pc, fetch_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    rst = 1'b1; start = 1'b1; branch_en = 1'b1; branch_target = 8'h07;
    tick();
    rst = 1'b0; start = 1'b0; branch_en = 1'b0;
    vectors++;
    if ({pc, instr, instr_pc, instr_valid, fetch_cnt, busy, halted} !== {8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_midrun: pc=%h instr=%h instr_pc=%h valid=%b cnt=%h busy=%b halted=%b, need all zero",
               pc, instr, instr_pc, instr_valid, fetch_cnt, busy, halted);
    end
    tick();
    vectors++;
    if ({busy, halted, instr_valid, pc} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_start_ignored: busy=%b halted=%b valid=%b pc=%h, need idle zeros", busy, halted, instr_valid, pc);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; branch_en = 1'b0; branch_target = 8'h00; instr_ready = 1'b1;
    test_reset();
    test_run();
    test_stall();
    test_branch();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value after reset and after each start.
REQ-002 Parameter HALT_CODE, default 16'hFFFF: instruction word that ends a run.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a run at RESET_PC; honoured only in IDLE or HALTED.
REQ-006 branch_en  input  1  redirect fetch to branch_target; honoured only in FETCH or DRAIN.
REQ-007 branch_target  input  8  new PC when branch_en is honoured.
REQ-008 pc  output  8  address to the program ROM (registered).
REQ-009 code  input  16  ROM word for the current pc (combinational ROM, same-cycle).
REQ-010 instr  output  16  registered instruction word.
REQ-011 instr_pc  output  8  address from which instr was fetched.
REQ-012 instr_valid  output  1  instr/instr_pc hold a valid word.
REQ-013 instr_ready  input  1  consumer accepts the word when instr_valid && instr_ready.
REQ-014 busy  output  1  high in FETCH and DRAIN.
REQ-015 halted  output  1  high in HALTED.
REQ-016 fetch_cnt  output  16  count of accepted words since the last start, saturating.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DRAIN and HALTED.
REQ-018 IDLE/HALTED with start=1: next state FETCH, pc<=RESET_PC, fetch_cnt<=0, instr_valid<=0.
REQ-019 Output slot free when !instr_valid || instr_ready.
REQ-020 FETCH, slot free, no branch: instr<=code, instr_pc<=pc, instr_valid<=1; if code!=HALT_CODE then pc<=pc+1, else pc held and state->DRAIN.
REQ-021 FETCH, slot not free (stall): pc, instr, instr_pc, instr_valid SHALL all hold.
REQ-022 First word latency: start sampled at edge N -> instr=word at RESET_PC with instr_valid=1 after edge N+1.
REQ-023 Sustained throughput with instr_ready=1 SHALL be one word per cycle.
REQ-024 pc increment SHALL wrap modulo 256 (8'hFF -> 8'h00) without any state change.
REQ-025 DRAIN: when the HALT_CODE word is accepted, instr_valid<=0 and state->HALTED; otherwise hold.
REQ-026 branch_en in FETCH or DRAIN: pc<=branch_target, instr_valid<=0 (pending word discarded, not counted), state->FETCH; branch overrides stall and halt capture in the same cycle.
REQ-027 branch_en in IDLE or HALTED SHALL be ignored; start in FETCH or DRAIN SHALL be ignored.
REQ-028 fetch_cnt SHALL increment on each accept (instr_valid && instr_ready), including the HALT_CODE word, and saturate at 16'hFFFF.
REQ-029 An accept in the same cycle as branch_en SHALL still be counted.

Reset
REQ-030 rst=1 at an edge: state IDLE, pc=RESET_PC, instr=16'h0000, instr_pc=8'h00, instr_valid=0, fetch_cnt=0, busy=0, halted=0.
REQ-031 rst SHALL override start and branch_en in the same cycle; reset mid-run discards the pending word.

Structure
REQ-032 Shared package fetch_pkg SHALL hold the state enum type and the default HALT_CODE and RESET_PC constants.
REQ-033 No sub-module; the ROM stays external and is connected through pc/code.
REQ-034 Target size is 120-250 lines of RTL.

Verification
The bench connects the existing program ROM block: word[k]=16'hkkkk for k=0..9, word[10]=16'hFFFF, all other words 0.
REQ-035 Reset, start pulse, instr_ready=1 -> words 0000,1111,...,9999,FFFF on consecutive cycles, instr_pc 0..10, then halted=1 and fetch_cnt=11.
REQ-036 instr_ready=0 for 3 cycles while instr=3333 -> instr, instr_pc=3 and pc=4 held; the stream resumes with 4444 with no loss or duplicate.
REQ-037 branch_en with branch_target=8 while instr=2222 and instr_ready=0 -> 2222 dropped, next word 8888 with instr_pc=8, fetch_cnt unchanged by the drop.
REQ-038 branch_target=8'hFF, run freely -> words at instr_pc FF then 00 (0000), wrap shows no glitch on busy.
REQ-039 rst asserted while instr_valid=1 in FETCH -> next cycle every output at its REQ-030 value; start asserted with rst the same cycle is ignored.
REQ-040 Start pulse while HALTED -> run restarts at pc 0 with fetch_cnt cleared; start pulse during FETCH -> no effect.
